// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one subtractor cell plus a
// borrow flip-flop. A start/done handshake frames each WIDTH-cycle operation.
// The result shift register is kept apart from the diff output register so a
// new operation never disturbs the last published result.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] sub_cell(input logic ai, input logic bi, input logic bin);
    logic d;
    logic bout;
    d    = ai ^ bi ^ bin;
    bout = (~ai & bi) | (~(ai ^ bi) & bin);
    return {bout, d};
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic             accept_s;
  logic             finish_s;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic [1:0]       cell_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;

  // Current bit of the operation through the single subtractor cell.
  always_comb begin
    cell_s = sub_cell(sa_r[0], sb_r[0], br_r);
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_DONE;
          finish_s     = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next_s = ST_RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_RUN);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Operand capture and per-bit shifting of operands, result and borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_r  <= '0;
      sb_r  <= '0;
      res_r <= '0;
      br_r  <= 1'b0;
      cnt_r <= '0;
    end else if (accept_s) begin
      sa_r  <= a;
      sb_r  <= b;
      br_r  <= 1'b0;
      cnt_r <= '0;
    end else if (state_r == ST_RUN) begin
      sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
      sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
      res_r <= {cell_s[0], res_r[WIDTH-1:1]};
      br_r  <= cell_s[1];
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Publish diff/borrow only on the final bit; they hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_r   <= '0;
      borrow_r <= 1'b0;
    end else if (finish_s) begin
      diff_r   <= {cell_s[0], res_r[WIDTH-1:1]};
      borrow_r <= cell_s[1];
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign diff   = diff_r;
  assign borrow = borrow_r;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial binary subtractor computing a - b over WIDTH cycles, LSB first.
- Uses a single half/full-subtractor cell and a borrow flip-flop.
- It is the inverse companion of the team's combinational half-adder cells: it produces the difference and borrow instead of sum and carry.
- Sits behind a start/done handshake so a controller can issue operands and collect results; it is area-minimal, so time is traded for gates.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when diff/borrow become valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow  output  1  final borrow-out; 1 iff a < b (unsigned).

Behaviour:
- Reset: rst is sampled on rising clk, is synchronous and active-high, and overrides everything, including mid-operation.
  - On reset: state=IDLE, busy=0, done=0, diff=0, borrow=0.
  - Shift registers, borrow FF and bit counter are cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a into shift register SA and b into SB.
  - Clears the internal borrow FF br=0 and sets bit counter cnt=0.
  - Goes to RUN; busy=1 from the next cycle.
  - start=0 stays in IDLE.
- RUN: each cycle uses ai=SA[0], bi=SB[0].
  - d = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - d is shifted into the result register at the MSB, and the register shifts right. After WIDTH shifts, bit 0 of the result is the first computed bit.
  - SA and SB shift right by one.
  - cnt increments.
  - When cnt == WIDTH-1, the current cycle is the last bit; go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - diff = result register; borrow = final br.
  - Next state is IDLE, unless start=1 in this cycle. In that case the new operands are latched and the state goes straight to RUN, giving back-to-back operation with no idle bubble.
- Latency: start accepted at edge N, so done is high in the cycle after edge N+WIDTH (WIDTH+1 cycles from start to done).
  - Throughput is one result per WIDTH+1 cycles.
- diff and borrow:
  - They change only on the transition into DONE and hold their value through IDLE.
  - During a following RUN they keep the previous result. The internal result register is separate from the diff output register.
- start while busy=1 (RUN): ignored; operands are not re-sampled and there is no error flag.
- a and b may change freely after acceptance; only the captured copies are used.
- Arithmetic:
  - diff = (a - b) mod 2^WIDTH.
  - borrow = (a < b).
  - When borrow=1, diff is the two's-complement of (b - a).
- Reset mid-RUN or in DONE aborts the operation with no done pulse. The block returns to IDLE with all outputs 0.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=4, rst high 2 cycles, then low -> busy=0, done=0, diff=0, borrow=0. Then a=9, b=3, start one cycle -> busy=1 for 4 cycles; done pulses one cycle, 5 cycles after start; diff=6, borrow=0.
- a=3, b=9 -> diff=4'hA, borrow=1. Edge operands: a=0, b=15 -> diff=1, borrow=1. a=5, b=5 -> diff=0, borrow=0. a=15, b=0 -> diff=15, borrow=0.
- start re-asserted with a=1, b=1 two cycles into a RUN of a=12, b=4 -> ignored; result diff=8, borrow=0; only one done pulse.
- start held high through DONE with new a=7, b=2 -> back-to-back operation. First result 8/0 appears on the done pulse. busy goes high the cycle after done; second done gives diff=5, borrow=0. diff holds 8 between the two done pulses.
- rst asserted in the 3rd RUN cycle -> next cycle busy=0, diff=0, borrow=0, and no done pulse. A fresh start with a=6, b=1 then yields diff=5.
- Randomised sweep of all 256 (a, b) pairs against the reference a-b and a<b, with random idle gaps and spurious start pulses while busy -> all results match.
